// File: rtl/sensor_packet_parser.sv
// Byte-stream parser for the dual-BNO085 packet: hunts for the header, collects the
// 28-byte payload and publishes 14 signed 16-bit values atomically. Optional: PARSER_TIMEOUT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// HUNT    | discard bytes until HEADER_BYTE, count discarded bytes
// COLLECT | store payload bytes into the shadow buffer until the last
module sensor_packet_parser #(
  parameter logic [7:0] HEADER_BYTE    = 8'hAA,
  parameter int         PAYLOAD_BYTES  = 28,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_ack,
  output logic signed [15:0] quat1_w,
  output logic signed [15:0] quat1_x,
  output logic signed [15:0] quat1_y,
  output logic signed [15:0] quat1_z,
  output logic signed [15:0] gyro1_x,
  output logic signed [15:0] gyro1_y,
  output logic signed [15:0] gyro1_z,
  output logic signed [15:0] quat2_w,
  output logic signed [15:0] quat2_x,
  output logic signed [15:0] quat2_y,
  output logic signed [15:0] quat2_z,
  output logic signed [15:0] gyro2_x,
  output logic signed [15:0] gyro2_y,
  output logic signed [15:0] gyro2_z,
  output logic               packet_valid,
  output logic               busy,
  output logic [7:0]         sync_err_cnt,
  output logic               timeout_abort
);

  localparam int NUM_VALS = PAYLOAD_BYTES / 2;
  localparam int IDX_W    = $clog2(PAYLOAD_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES);

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] byte_index;
  logic [7:0]       shadow [PAYLOAD_BYTES+1];
  logic [15:0]      vals_q [NUM_VALS];
  logic [15:0]      vals_d [NUM_VALS];

  logic accept;
  logic hdr_hit;
  logic store;
  logic pkt_done;
  logic discard;
  logic abort;
  logic gap_expired;

  assign accept = rx_valid && rx_ack;

  always_ff @(posedge clk) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    hdr_hit  = 1'b0;
    store    = 1'b0;
    pkt_done = 1'b0;
    discard  = 1'b0;
    abort    = 1'b0;
    case (state_q)
      HUNT: begin
        if (accept) begin
          if (rx_data == HEADER_BYTE) begin
            hdr_hit = 1'b1;
            state_d = COLLECT;
          end else begin
            discard = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          store = 1'b1;
          if (byte_index == LAST_IDX) begin
            pkt_done = 1'b1;
            state_d  = HUNT;
          end
        end else if (gap_expired) begin
          abort   = 1'b1;
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // The final byte bypasses the shadow buffer so all values load on its accept edge.
  always_comb begin
    for (int k = 0; k < NUM_VALS; k++) begin
      vals_d[k][7:0] = shadow[2*k+1];
      if (k == NUM_VALS - 1) vals_d[k][15:8] = rx_data;
      else                   vals_d[k][15:8] = shadow[2*k+2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ack       <= 1'b0;
      byte_index   <= '0;
      packet_valid <= 1'b0;
      sync_err_cnt <= '0;
      for (int i = 0; i <= PAYLOAD_BYTES; i++) shadow[i] <= '0;
      for (int k = 0; k < NUM_VALS; k++) vals_q[k] <= '0;
    end else begin
      rx_ack       <= rx_valid && !rx_ack;
      packet_valid <= pkt_done;

      if (hdr_hit)               byte_index <= IDX_W'(1);
      else if (pkt_done || abort) byte_index <= '0;
      else if (store)            byte_index <= byte_index + IDX_W'(1);

      if (store) shadow[byte_index] <= rx_data;

      if (pkt_done) begin
        for (int k = 0; k < NUM_VALS; k++) vals_q[k] <= vals_d[k];
      end

      if (discard && (sync_err_cnt != 8'hFF)) sync_err_cnt <= sync_err_cnt + 8'd1;
    end
  end

`ifdef PARSER_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(TIMEOUT_CYCLES - 1);

  logic [GAP_W-1:0] gap_cnt;

  // Down-counter reloads on every accept and outside COLLECT; zero means the gap is too long.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt       <= GAP_LOAD;
      timeout_abort <= 1'b0;
    end else begin
      timeout_abort <= abort;
      if ((state_q != COLLECT) || accept) gap_cnt <= GAP_LOAD;
      else if (gap_cnt != '0)             gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

  assign gap_expired = (state_q == COLLECT) && (gap_cnt == '0);
`else
  assign gap_expired   = 1'b0;
  assign timeout_abort = 1'b0;
`endif

  assign busy = (state_q == COLLECT);

  assign quat1_w = vals_q[0];
  assign quat1_x = vals_q[1];
  assign quat1_y = vals_q[2];
  assign quat1_z = vals_q[3];
  assign gyro1_x = vals_q[4];
  assign gyro1_y = vals_q[5];
  assign gyro1_z = vals_q[6];
  assign quat2_w = vals_q[7];
  assign quat2_x = vals_q[8];
  assign quat2_y = vals_q[9];
  assign quat2_z = vals_q[10];
  assign gyro2_x = vals_q[11];
  assign gyro2_y = vals_q[12];
  assign gyro2_z = vals_q[13];

endmodule
